axi_rd_arb_2to1: RTL and testbench

AXI_RD_ARB_2TO1 -- requirements
Module: axi_rd_arb_2to1

---
 rtl/axi_rd_arb_2to1_if.sv | 25 ++
 rtl/axi_rd_arb_2to1.sv | 166 ++++++++++++++++
 tb/tb_axi_rd_arb_2to1.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_rd_arb_2to1_if.sv
// One read link (address + data channel) between a requester (master) and a responder (slave).
interface axi_rd_arb_2to1_if #(
    parameter int ID_W = 4
);
    logic [ID_W-1:0] RD_ID;
    logic [31:0]     RD_ADDR;
    logic [7:0]      RD_LEN;
    logic            RD_ADDR_VALID;
    logic            RD_ADDR_READY;
    logic [ID_W-1:0] RD_BACK_ID;
    logic [31:0]     RD_DATA;
    logic            RD_DATA_LAST;
    logic            RD_DATA_VALID;
    logic            RD_DATA_READY;

    modport master (
        output RD_ID, RD_ADDR, RD_LEN, RD_ADDR_VALID, RD_DATA_READY,
        input  RD_ADDR_READY, RD_BACK_ID, RD_DATA, RD_DATA_LAST, RD_DATA_VALID
    );

    modport slave (
        input  RD_ID, RD_ADDR, RD_LEN, RD_ADDR_VALID, RD_DATA_READY,
        output RD_ADDR_READY, RD_BACK_ID, RD_DATA, RD_DATA_LAST, RD_DATA_VALID
    );
endinterface

// File: rtl/axi_rd_arb_2to1.sv
// Two-master read arbiter sharing one slave, one burst in flight at a time.
// Define RD_ARB_RR_EN for round-robin tie-breaking; otherwise M0 wins ties.
module axi_rd_arb_2to1 #(
    parameter int ID_W = 4
) (
    input  logic              clk,
    input  logic              rstn,
    axi_rd_arb_2to1_if.slave  m0,
    axi_rd_arb_2to1_if.slave  m1,
    axi_rd_arb_2to1_if.master s,
    output logic              ARB_GNT,
    output logic              ARB_BUSY,
    output logic              LEN_ERR
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic       req_any;
    logic       win;
    logic       addr_hs;
    logic       data_hs;
    logic [7:0] len_q;
    logic [8:0] beat_cnt;
    logic       ovf_q;
    logic       len_err_nxt;
    logic       ovf_set;

    assign req_any = m0.RD_ADDR_VALID | m1.RD_ADDR_VALID;

`ifdef RD_ARB_RR_EN
    logic last_ptr;

    // Ties go to the master that did not win last time.
    always_comb begin
        if (m0.RD_ADDR_VALID && m1.RD_ADDR_VALID)
            win = ~last_ptr;
        else
            win = ~m0.RD_ADDR_VALID;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            last_ptr <= 1'b1;
        else if (state == IDLE && req_any)
            last_ptr <= win;
    end
`else
    assign win = ~m0.RD_ADDR_VALID;
`endif

    // Bus muxing; everything idles at zero outside the phase that owns it.
    always_comb begin
        s.RD_ID          = '0;
        s.RD_ADDR        = '0;
        s.RD_LEN         = '0;
        s.RD_ADDR_VALID  = 1'b0;
        s.RD_DATA_READY  = 1'b0;
        m0.RD_ADDR_READY = 1'b0;
        m1.RD_ADDR_READY = 1'b0;
        m0.RD_DATA_VALID = 1'b0;
        m1.RD_DATA_VALID = 1'b0;
        m0.RD_BACK_ID    = '0;
        m1.RD_BACK_ID    = '0;
        m0.RD_DATA       = '0;
        m1.RD_DATA       = '0;
        m0.RD_DATA_LAST  = 1'b0;
        m1.RD_DATA_LAST  = 1'b0;
        case (state)
            ADDR: begin
                if (ARB_GNT) begin
                    s.RD_ID          = m1.RD_ID;
                    s.RD_ADDR        = m1.RD_ADDR;
                    s.RD_LEN         = m1.RD_LEN;
                    s.RD_ADDR_VALID  = m1.RD_ADDR_VALID;
                    m1.RD_ADDR_READY = s.RD_ADDR_READY;
                end else begin
                    s.RD_ID          = m0.RD_ID;
                    s.RD_ADDR        = m0.RD_ADDR;
                    s.RD_LEN         = m0.RD_LEN;
                    s.RD_ADDR_VALID  = m0.RD_ADDR_VALID;
                    m0.RD_ADDR_READY = s.RD_ADDR_READY;
                end
            end
            DATA: begin
                m0.RD_BACK_ID   = s.RD_BACK_ID;
                m1.RD_BACK_ID   = s.RD_BACK_ID;
                m0.RD_DATA      = s.RD_DATA;
                m1.RD_DATA      = s.RD_DATA;
                m0.RD_DATA_LAST = s.RD_DATA_LAST;
                m1.RD_DATA_LAST = s.RD_DATA_LAST;
                if (ARB_GNT) begin
                    s.RD_DATA_READY  = m1.RD_DATA_READY;
                    m1.RD_DATA_VALID = s.RD_DATA_VALID;
                end else begin
                    s.RD_DATA_READY  = m0.RD_DATA_READY;
                    m0.RD_DATA_VALID = s.RD_DATA_VALID;
                end
            end
            default: ;
        endcase
    end

    assign addr_hs  = (state == ADDR) && s.RD_ADDR_VALID && s.RD_ADDR_READY;
    assign data_hs  = (state == DATA) && s.RD_DATA_VALID && s.RD_DATA_READY;
    assign ARB_BUSY = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_any) state_nxt = ADDR;
            ADDR:    if (addr_hs) state_nxt = DATA;
            DATA:    if (data_hs && s.RD_DATA_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Overrun = a non-LAST beat whose pre-increment count is already past LEN.
    // It is reported once per burst and masks the later LAST-mismatch report.
    always_comb begin
        len_err_nxt = 1'b0;
        ovf_set     = 1'b0;
        if (data_hs && !ovf_q) begin
            if (s.RD_DATA_LAST) begin
                len_err_nxt = (beat_cnt != {1'b0, len_q});
            end else if (beat_cnt > {1'b0, len_q}) begin
                len_err_nxt = 1'b1;
                ovf_set     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            ARB_GNT <= 1'b0;
            LEN_ERR <= 1'b0;
        end else begin
            state   <= state_nxt;
            LEN_ERR <= len_err_nxt;
            if (state == IDLE && req_any)
                ARB_GNT <= win;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len_q    <= 8'd0;
            beat_cnt <= 9'd0;
            ovf_q    <= 1'b0;
        end else if (addr_hs) begin
            len_q    <= s.RD_LEN;
            beat_cnt <= 9'd0;
            ovf_q    <= 1'b0;
        end else if (data_hs) begin
            beat_cnt <= beat_cnt + 9'd1;
            if (ovf_set)
                ovf_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_rd_arb_2to1.sv
// Directed bench for axi_rd_arb_2to1: single bursts, tie arbitration, back-pressure, length errors, reset mid-burst.
module tb_axi_rd_arb_2to1;
    localparam int ID_W = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic ARB_GNT, ARB_BUSY, LEN_ERR;
    int   n_assert = 0;
    int   n_fail   = 0;

    axi_rd_arb_2to1_if #(.ID_W(ID_W)) m0_if ();
    axi_rd_arb_2to1_if #(.ID_W(ID_W)) m1_if ();
    axi_rd_arb_2to1_if #(.ID_W(ID_W)) s_if ();

    axi_rd_arb_2to1 #(.ID_W(ID_W)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .m0       (m0_if),
        .m1       (m1_if),
        .s        (s_if),
        .ARB_GNT  (ARB_GNT),
        .ARB_BUSY (ARB_BUSY),
        .LEN_ERR  (LEN_ERR)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_m(input bit idx, input bit vld, input logic [31:0] addr,
                         input logic [7:0] len, input logic [ID_W-1:0] id);
        if (idx) begin
            m1_if.RD_ADDR_VALID = vld; m1_if.RD_ADDR = addr; m1_if.RD_LEN = len; m1_if.RD_ID = id;
        end else begin
            m0_if.RD_ADDR_VALID = vld; m0_if.RD_ADDR = addr; m0_if.RD_LEN = len; m0_if.RD_ID = id;
        end
    endtask

    // Called in IDLE with requests up: grant edge, check the muxed address, then handshake into DATA.
    task automatic addr_phase(input string tag, input bit exp_gnt,
                              input logic [31:0] exp_addr, input logic [7:0] exp_len);
        tick();
        settle();
        chk({tag, "_gnt"}, ARB_GNT, exp_gnt);
        chk({tag, "_busy"}, ARB_BUSY, 1);
        chk({tag, "_s_avalid"}, s_if.RD_ADDR_VALID, 1);
        chk({tag, "_s_addr"}, s_if.RD_ADDR, exp_addr);
        chk({tag, "_s_len"}, s_if.RD_LEN, exp_len);
        s_if.RD_ADDR_READY = 1'b1;
        settle();
        chk({tag, "_m0_aready"}, m0_if.RD_ADDR_READY, !exp_gnt);
        chk({tag, "_m1_aready"}, m1_if.RD_ADDR_READY, exp_gnt);
        tick();
        s_if.RD_ADDR_READY = 1'b0;
    endtask

    initial begin
        logic exp_g [4];
        logic exp_e [4];
        int   beat;
        int   cyc;
        logic rdy;

        m0_if.RD_ID = '0; m0_if.RD_ADDR = '0; m0_if.RD_LEN = '0;
        m0_if.RD_ADDR_VALID = 1'b0; m0_if.RD_DATA_READY = 1'b0;
        m1_if.RD_ID = '0; m1_if.RD_ADDR = '0; m1_if.RD_LEN = '0;
        m1_if.RD_ADDR_VALID = 1'b0; m1_if.RD_DATA_READY = 1'b0;
        s_if.RD_ADDR_READY = 1'b0; s_if.RD_BACK_ID = '0; s_if.RD_DATA = '0;
        s_if.RD_DATA_LAST = 1'b0; s_if.RD_DATA_VALID = 1'b0;

        #12;
        chk("rst_busy", ARB_BUSY, 0);
        chk("rst_gnt", ARB_GNT, 0);
        chk("rst_lenerr", LEN_ERR, 0);
        chk("rst_s_avalid", s_if.RD_ADDR_VALID, 0);
        chk("rst_s_dready", s_if.RD_DATA_READY, 0);
        rstn = 1'b1;
        tick();

        // M0 alone, ADDR 0x10, LEN 3
        set_m(0, 1, 32'h10, 8'd3, 4'd5);
        m0_if.RD_DATA_READY = 1'b1;
        settle();
        chk("r18_idle_avalid", s_if.RD_ADDR_VALID, 0);
        addr_phase("r18", 0, 32'h10, 8'd3);
        set_m(0, 0, 32'h0, 8'd0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            s_if.RD_DATA_VALID = 1'b1;
            s_if.RD_DATA = 32'hA0 + i;
            s_if.RD_BACK_ID = 4'd5;
            s_if.RD_DATA_LAST = (i == 3);
            settle();
            chk("r18_m0_dvalid", m0_if.RD_DATA_VALID, 1);
            chk("r18_m1_dvalid", m1_if.RD_DATA_VALID, 0);
            chk("r18_m0_data", m0_if.RD_DATA, 32'hA0 + i);
            chk("r18_m1_data", m1_if.RD_DATA, 32'hA0 + i);
            chk("r18_backid", m0_if.RD_BACK_ID, 4'd5);
            chk("r18_s_dready", s_if.RD_DATA_READY, 1);
            chk("r18_lenerr", LEN_ERR, 0);
            tick();
        end
        s_if.RD_DATA_VALID = 1'b0;
        s_if.RD_DATA_LAST = 1'b0;
        settle();
        chk("r18_end_busy", ARB_BUSY, 0);
        chk("r18_end_lenerr", LEN_ERR, 0);
        chk("r18_end_m0_dvalid", m0_if.RD_DATA_VALID, 0);

        // Simultaneous requests from a fresh reset
        rstn = 1'b0;
        settle();
        rstn = 1'b1;
        tick();
`ifdef RD_ARB_RR_EN
        exp_g[0] = 1'b0; exp_g[1] = 1'b1; exp_g[2] = 1'b0; exp_g[3] = 1'b1;
`else
        exp_g[0] = 1'b0; exp_g[1] = 1'b0; exp_g[2] = 1'b0; exp_g[3] = 1'b0;
`endif
        set_m(0, 1, 32'h100, 8'd0, 4'd1);
        set_m(1, 1, 32'h200, 8'd0, 4'd2);
        m0_if.RD_DATA_READY = 1'b1;
        m1_if.RD_DATA_READY = 1'b1;
        for (int k = 0; k < 4; k++) begin
            addr_phase("r19", exp_g[k], exp_g[k] ? 32'h200 : 32'h100, 8'd0);
            s_if.RD_DATA_VALID = 1'b1;
            s_if.RD_DATA_LAST = 1'b1;
            settle();
            chk("r19_gnt_dvalid", exp_g[k] ? m1_if.RD_DATA_VALID : m0_if.RD_DATA_VALID, 1);
            tick();
            s_if.RD_DATA_VALID = 1'b0;
            s_if.RD_DATA_LAST = 1'b0;
            settle();
            chk("r19_idle_gap", ARB_BUSY, 0);
        end
        set_m(0, 0, 32'h0, 8'd0, 4'd0);
        set_m(1, 0, 32'h0, 8'd0, 4'd0);

        // M1, LEN 7, DATA_READY toggling
        set_m(1, 1, 32'h300, 8'd7, 4'd3);
        addr_phase("r20", 1, 32'h300, 8'd7);
        set_m(1, 0, 32'h0, 8'd0, 4'd0);
        beat = 0;
        cyc = 0;
        s_if.RD_DATA_VALID = 1'b1;
        while (beat < 8 && cyc < 40) begin
            rdy = (cyc % 2 == 0);
            m1_if.RD_DATA_READY = rdy;
            s_if.RD_DATA = 32'h3000 + beat;
            s_if.RD_DATA_LAST = (beat == 7);
            settle();
            chk("r20_s_dready", s_if.RD_DATA_READY, rdy);
            chk("r20_m1_dvalid", m1_if.RD_DATA_VALID, 1);
            chk("r20_m0_dvalid", m0_if.RD_DATA_VALID, 0);
            chk("r20_lenerr", LEN_ERR, 0);
            tick();
            if (rdy) beat++;
            cyc++;
        end
        chk("r20_beats", beat, 8);
        s_if.RD_DATA_VALID = 1'b0;
        s_if.RD_DATA_LAST = 1'b0;
        m1_if.RD_DATA_READY = 1'b1;
        settle();
        chk("r20_end_busy", ARB_BUSY, 0);
        chk("r20_end_lenerr", LEN_ERR, 0);

        // LEN 3, LAST on 2nd beat
        set_m(0, 1, 32'h40, 8'd3, 4'd4);
        addr_phase("r21a", 0, 32'h40, 8'd3);
        set_m(0, 0, 32'h0, 8'd0, 4'd0);
        s_if.RD_DATA_VALID = 1'b1;
        s_if.RD_DATA_LAST = 1'b0;
        tick();
        settle();
        chk("r21a_b1_lenerr", LEN_ERR, 0);
        chk("r21a_b1_busy", ARB_BUSY, 1);
        s_if.RD_DATA_LAST = 1'b1;
        tick();
        s_if.RD_DATA_VALID = 1'b0;
        s_if.RD_DATA_LAST = 1'b0;
        settle();
        chk("r21a_pulse", LEN_ERR, 1);
        chk("r21a_idle", ARB_BUSY, 0);
        tick();
        chk("r21a_pulse_end", LEN_ERR, 0);

        // LEN 1, LAST on 4th beat
        set_m(0, 1, 32'h50, 8'd1, 4'd4);
        addr_phase("r21b", 0, 32'h50, 8'd1);
        set_m(0, 0, 32'h0, 8'd0, 4'd0);
        exp_e[0] = 1'b0; exp_e[1] = 1'b0; exp_e[2] = 1'b1; exp_e[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_if.RD_DATA_VALID = 1'b1;
            s_if.RD_DATA_LAST = (i == 3);
            tick();
            if (i == 3) begin
                s_if.RD_DATA_VALID = 1'b0;
                s_if.RD_DATA_LAST = 1'b0;
            end
            settle();
            chk("r21b_lenerr", LEN_ERR, exp_e[i]);
        end
        chk("r21b_idle", ARB_BUSY, 0);
        tick();
        chk("r21b_quiet", LEN_ERR, 0);

        // Reset in the middle of a LEN 7 burst
        set_m(1, 1, 32'h600, 8'd7, 4'd6);
        addr_phase("r22", 1, 32'h600, 8'd7);
        set_m(1, 0, 32'h0, 8'd0, 4'd0);
        m1_if.RD_DATA_READY = 1'b1;
        s_if.RD_DATA_VALID = 1'b1;
        s_if.RD_DATA = 32'h77;
        tick();
        tick();
        settle();
        chk("r22_pre_dvalid", m1_if.RD_DATA_VALID, 1);
        rstn = 1'b0;
        settle();
        chk("r22_rst_busy", ARB_BUSY, 0);
        chk("r22_rst_gnt", ARB_GNT, 0);
        chk("r22_rst_s_dready", s_if.RD_DATA_READY, 0);
        chk("r22_rst_m1_dvalid", m1_if.RD_DATA_VALID, 0);
        chk("r22_rst_m1_data", m1_if.RD_DATA, 0);
        chk("r22_rst_lenerr", LEN_ERR, 0);
        chk("r22_rst_s_avalid", s_if.RD_ADDR_VALID, 0);
        tick();
        rstn = 1'b1;
        tick();
        settle();
        chk("r22_post_busy", ARB_BUSY, 0);
        chk("r22_post_s_dready", s_if.RD_DATA_READY, 0);
        chk("r22_post_m1_dvalid", m1_if.RD_DATA_VALID, 0);
        s_if.RD_DATA_VALID = 1'b0;
        set_m(0, 1, 32'h700, 8'd2, 4'd7);
        addr_phase("r22_new", 0, 32'h700, 8'd2);
        set_m(0, 0, 32'h0, 8'd0, 4'd0);
        settle();
        chk("r22_new_busy", ARB_BUSY, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
